// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
// The fetch stage is the master: it drives the request and address and
// receives the grant and the response.
interface instruction_fetch_stage_if;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;

    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_GNT,
        input  IMEM_RVALID,
        input  IMEM_RDATA
    );

    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_GNT,
        output IMEM_RVALID,
        output IMEM_RDATA
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// parks a response in a one-entry skid buffer when decode is stalled, and
// feeds the IF/ID pipeline register. A flush drops IF/ID, the skid buffer
// and any response still in flight.
// Optional feature macro: FETCH_PERF_COUNTERS_EN enables the fetch and
// wait-cycle counters; without it both counter ports read as zero.
module instruction_fetch_stage #(
    parameter logic [31:0] NOP_INSTRUCTION = 32'h00000013
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [31:0]                 PC,
    output logic                        FETCH_STALL,
    instruction_fetch_stage_if.master   imem,
    input  logic                        STALL_DECODING_STAGE,
    input  logic                        CLEAR_DECODING_STAGE,
    output logic [31:0]                 PC_DECODING,
    output logic [31:0]                 INSTRUCTION_DECODING,
    output logic                        VALID_DECODING,
    output logic [31:0]                 FETCH_COUNT,
    output logic [31:0]                 FETCH_WAIT_COUNT
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        kill;
    logic        kill_next;
    logic [31:0] pending_pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    logic        fetch_grant;
    logic        ifid_free;
    logic        load_ifid;
    logic        load_from_skid;
    logic        write_skid;
    logic        drop_skid;

    assign imem.IMEM_REQ  = (state == IDLE) && !CLEAR_DECODING_STAGE;
    assign imem.IMEM_ADDR = PC;
    assign fetch_grant    = imem.IMEM_REQ && imem.IMEM_GNT;
    assign FETCH_STALL    = !fetch_grant;
    assign ifid_free      = !valid_q || !STALL_DECODING_STAGE;

    assign VALID_DECODING       = valid_q;
    assign PC_DECODING          = pc_q;
    assign INSTRUCTION_DECODING = valid_q ? instr_q : NOP_INSTRUCTION;

    // Next-state and IF/ID / skid-buffer load decisions; a flush outranks a stall.
    always_comb begin
        state_next     = state;
        kill_next      = kill;
        load_ifid      = 1'b0;
        load_from_skid = 1'b0;
        write_skid     = 1'b0;
        drop_skid      = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_grant) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (CLEAR_DECODING_STAGE) begin
                    if (imem.IMEM_RVALID) begin
                        kill_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        kill_next = 1'b1;
                    end
                end else if (imem.IMEM_RVALID) begin
                    state_next = IDLE;
                    if (kill) begin
                        kill_next = 1'b0;
                    end else if (ifid_free) begin
                        load_ifid = 1'b1;
                    end else begin
                        write_skid = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (CLEAR_DECODING_STAGE) begin
                    drop_skid  = 1'b1;
                    state_next = IDLE;
                end else if (!STALL_DECODING_STAGE && skid_valid) begin
                    load_ifid      = 1'b1;
                    load_from_skid = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM, in-flight address, skid buffer and IF/ID register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            kill       <= 1'b0;
            pending_pc <= 32'h0;
            skid_valid <= 1'b0;
            skid_pc    <= 32'h0;
            skid_instr <= 32'h0;
            valid_q    <= 1'b0;
            pc_q       <= 32'h0;
            instr_q    <= 32'h0;
        end else begin
            state <= state_next;
            kill  <= kill_next;
            if (fetch_grant) begin
                pending_pc <= PC;
            end
            if (write_skid) begin
                skid_valid <= 1'b1;
                skid_pc    <= pending_pc;
                skid_instr <= imem.IMEM_RDATA;
            end else if (load_from_skid || drop_skid) begin
                skid_valid <= 1'b0;
            end
            if (CLEAR_DECODING_STAGE) begin
                valid_q <= 1'b0;
            end else if (load_ifid) begin
                valid_q <= 1'b1;
                pc_q    <= load_from_skid ? skid_pc : pending_pc;
                instr_q <= load_from_skid ? skid_instr : imem.IMEM_RDATA;
            end else if (!STALL_DECODING_STAGE) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_count_q;
    logic [31:0] wait_count_q;

    // Count IF/ID loads and cycles spent waiting on a response; both wrap.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_count_q <= 32'h0;
            wait_count_q  <= 32'h0;
        end else begin
            if (load_ifid) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (state == WAIT) begin
                wait_count_q <= wait_count_q + 32'd1;
            end
        end
    end

    assign FETCH_COUNT      = fetch_count_q;
    assign FETCH_WAIT_COUNT = wait_count_q;
`else
    assign FETCH_COUNT      = 32'h0;
    assign FETCH_WAIT_COUNT = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: a transaction-level model
// (outstanding request, parked-response queue, IF/ID entry) is compared with
// the DUT every cycle, plus directed scenarios with hand-computed values.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        fetch_stall;
    logic        stall_dec;
    logic        clear_dec;
    logic [31:0] pc_dec;
    logic [31:0] instr_dec;
    logic        valid_dec;
    logic [31:0] fetch_count;
    logic [31:0] fetch_wait_count;

    int checks = 0;
    int errors = 0;

    instruction_fetch_stage_if bus ();

    instruction_fetch_stage #(.NOP_INSTRUCTION(NOP)) dut (
        .CLK                  (clk),
        .RST_N                (rst_n),
        .PC                   (pc),
        .FETCH_STALL          (fetch_stall),
        .imem                 (bus),
        .STALL_DECODING_STAGE (stall_dec),
        .CLEAR_DECODING_STAGE (clear_dec),
        .PC_DECODING          (pc_dec),
        .INSTRUCTION_DECODING (instr_dec),
        .VALID_DECODING       (valid_dec),
        .FETCH_COUNT          (fetch_count),
        .FETCH_WAIT_COUNT     (fetch_wait_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: what the fetch stage holds, in transaction terms.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      m_parked[$];
    bit          m_out_active;
    bit          m_out_killed;
    logic [31:0] m_out_pc;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int unsigned m_fetches;
    int unsigned m_waits;

    function automatic bit model_req();
        return !m_out_active && (m_parked.size() == 0) && !clear_dec;
    endfunction

    task automatic model_reset();
        m_parked.delete();
        m_out_active = 0;
        m_out_killed = 0;
        m_out_pc     = 32'h0;
        m_valid      = 0;
        m_pc         = 32'h0;
        m_instr      = 32'h0;
        m_fetches    = 0;
        m_waits      = 0;
    endtask

    task automatic model_deliver(input logic [31:0] p, input logic [31:0] i);
        m_valid = 1;
        m_pc    = p;
        m_instr = i;
        m_fetches++;
    endtask

    task automatic model_step();
        bit     req;
        bit     slot_free;
        bit     delivered;
        entry_t e;
        req       = model_req();
        slot_free = !m_valid || !stall_dec;
        delivered = 0;
        if (m_out_active) m_waits++;
        if (clear_dec) begin
            m_valid = 0;
            m_parked.delete();
            if (m_out_active && bus.IMEM_RVALID) m_out_active = 0;
            else if (m_out_active) m_out_killed = 1;
        end else begin
            if (m_parked.size() > 0 && !stall_dec) begin
                e = m_parked.pop_front();
                model_deliver(e.pc, e.instr);
                delivered = 1;
            end else if (m_out_active && bus.IMEM_RVALID) begin
                m_out_active = 0;
                if (!m_out_killed) begin
                    if (slot_free) begin
                        model_deliver(m_out_pc, bus.IMEM_RDATA);
                        delivered = 1;
                    end else begin
                        e.pc    = m_out_pc;
                        e.instr = bus.IMEM_RDATA;
                        m_parked.push_back(e);
                    end
                end
                m_out_killed = 0;
            end
            if (!delivered && !stall_dec) m_valid = 0;
            if (req && bus.IMEM_GNT) begin
                m_out_active = 1;
                m_out_killed = 0;
                m_out_pc     = pc;
            end
        end
    endtask

    // Advance the model on every edge, or immediately on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model shortly after each edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check_output("cmp_valid", {31'h0, valid_dec}, {31'h0, m_valid});
            check_output("cmp_instr", instr_dec, m_valid ? m_instr : NOP);
            if (m_valid) check_output("cmp_pc", pc_dec, m_pc);
            check_output("cmp_req", {31'h0, bus.IMEM_REQ}, {31'h0, model_req()});
            check_output("cmp_addr", bus.IMEM_ADDR, pc);
            check_output("cmp_fetch_stall", {31'h0, fetch_stall},
                         {31'h0, !(model_req() && bus.IMEM_GNT)});
`ifdef FETCH_PERF_COUNTERS_EN
            check_output("cmp_fetch_count", fetch_count, m_fetches);
            check_output("cmp_wait_count", fetch_wait_count, m_waits);
`else
            check_output("cmp_fetch_count", fetch_count, 32'h0);
            check_output("cmp_wait_count", fetch_wait_count, 32'h0);
`endif
        end
    end

    task automatic apply_stimulus(input logic [31:0] p, input logic g, input logic rv,
                                  input logic [31:0] rd, input logic st, input logic cl);
        @(negedge clk);
        pc              = p;
        bus.IMEM_GNT    = g;
        bus.IMEM_RVALID = rv;
        bus.IMEM_RDATA  = rd;
        stall_dec       = st;
        clear_dec       = cl;
    endtask

    task automatic step(input logic [31:0] p, input logic g, input logic rv,
                        input logic [31:0] rd, input logic st, input logic cl);
        apply_stimulus(p, g, rv, rd, st, cl);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n           = 1'b0;
        pc              = 32'h0;
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b0;
        bus.IMEM_RDATA  = 32'h0;
        stall_dec       = 1'b0;
        clear_dec       = 1'b0;
        #1;
        check_output("reset_valid", {31'h0, valid_dec}, 32'h0);
        check_output("reset_instr", instr_dec, NOP);
        check_output("reset_pc", pc_dec, 32'h0);
        check_output("reset_fetch_count", fetch_count, 32'h0);
        check_output("reset_wait_count", fetch_wait_count, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back fetch: valid two edges after the granted request.
        step(32'h0, 1, 0, 32'h0, 0, 0);
        check_output("b2b_valid_edge1", {31'h0, valid_dec}, 32'h0);
        step(32'h4, 0, 1, 32'h00500093, 0, 0);
        check_output("b2b_valid", {31'h0, valid_dec}, 32'h1);
        check_output("b2b_pc", pc_dec, 32'h0);
        check_output("b2b_instr", instr_dec, 32'h00500093);
        check_output("model_pin_instr", m_instr, 32'h00500093);

        // Decode stall: response parks in the skid buffer, IF/ID held.
        step(32'h4, 1, 0, 32'h0, 1, 0);
        check_output("stall_hold_instr0", instr_dec, 32'h00500093);
        step(32'h8, 0, 1, 32'h00208133, 1, 0);
        check_output("stall_hold_instr", instr_dec, 32'h00500093);
        check_output("stall_hold_valid", {31'h0, valid_dec}, 32'h1);
        check_output("stall_hold_noreq", {31'h0, bus.IMEM_REQ}, 32'h0);
        step(32'h8, 0, 0, 32'h0, 1, 0);
        check_output("stall_hold_instr2", instr_dec, 32'h00500093);
        step(32'h8, 0, 0, 32'h0, 0, 0);
        check_output("unstall_instr", instr_dec, 32'h00208133);
        check_output("unstall_pc", pc_dec, 32'h4);

        // Flush while waiting: the late response is dropped.
        step(32'h10, 1, 0, 32'h0, 0, 0);
        step(32'h14, 0, 0, 32'h0, 0, 1);
        step(32'h14, 0, 1, 32'hdeadbeef, 0, 0);
        check_output("flush_wait_valid", {31'h0, valid_dec}, 32'h0);
        check_output("flush_wait_instr", instr_dec, 32'h00000013);

        // Response and flush in the same cycle: also dropped.
        step(32'h18, 1, 0, 32'h0, 0, 0);
        step(32'h1c, 0, 1, 32'hcafef00d, 0, 1);
        check_output("flush_same_valid", {31'h0, valid_dec}, 32'h0);
        apply_stimulus(32'h1c, 0, 0, 32'h0, 0, 0);
        #1;
        check_output("flush_same_req_back", {31'h0, bus.IMEM_REQ}, 32'h1);

        // Memory wait: grant withheld for three cycles.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(32'h20, 0, 0, 32'h0, 0, 0);
            #1;
            check_output("memwait_stall", {31'h0, fetch_stall}, 32'h1);
            check_output("memwait_addr", bus.IMEM_ADDR, 32'h20);
        end
        apply_stimulus(32'h20, 1, 0, 32'h0, 0, 0);
        #1;
        check_output("memwait_granted", {31'h0, fetch_stall}, 32'h0);
        step(32'h24, 0, 1, 32'h00c00293, 0, 0);
        check_output("memwait_instr", instr_dec, 32'h00c00293);
        check_output("memwait_pc", pc_dec, 32'h20);

        // Flush while a response is parked.
        step(32'h40, 1, 0, 32'h0, 0, 0);
        step(32'h44, 0, 1, 32'h00300193, 0, 0);
        step(32'h44, 1, 0, 32'h0, 1, 0);
        step(32'h48, 0, 1, 32'h00400213, 1, 0);
        step(32'h48, 0, 0, 32'h0, 1, 1);
        check_output("flush_hold_valid", {31'h0, valid_dec}, 32'h0);
        check_output("flush_hold_instr", instr_dec, NOP);
        apply_stimulus(32'h48, 0, 0, 32'h0, 0, 0);
        #1;
        check_output("flush_hold_req", {31'h0, bus.IMEM_REQ}, 32'h1);

        // Asynchronous reset in the middle of a wait, then a stale response.
        step(32'h30, 1, 0, 32'h0, 0, 0);
        step(32'h34, 0, 1, 32'h00100113, 0, 0);
        step(32'h34, 1, 0, 32'h0, 1, 0);
        check_output("areset_pre_valid", {31'h0, valid_dec}, 32'h1);
        apply_stimulus(32'h34, 0, 0, 32'h0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("areset_valid", {31'h0, valid_dec}, 32'h0);
        check_output("areset_instr", instr_dec, NOP);
        check_output("areset_pc", pc_dec, 32'h0);
        check_output("areset_fetch_count", fetch_count, 32'h0);
        @(negedge clk);
        bus.IMEM_GNT = 1'b0;
        rst_n        = 1'b1;
        step(32'h38, 0, 1, 32'hbad0bad0, 0, 0);
        check_output("stale_rvalid_valid", {31'h0, valid_dec}, 32'h0);
        check_output("stale_rvalid_instr", instr_dec, NOP);

        // Counters: four fetches, each spending two cycles waiting.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(32'h100 + 32'(i * 4), 1, 0, 32'h0, 0, 0);
            step(32'h200, 0, 0, 32'h0, 0, 0);
            step(32'h200, 0, 1, 32'h00000093 + 32'(i), 0, 0);
        end
        check_output("perf_last_instr", instr_dec, 32'h00000096);
        check_output("perf_last_pc", pc_dec, 32'h10c);
`ifdef FETCH_PERF_COUNTERS_EN
        check_output("perf_fetch_count", fetch_count, 32'd4);
        check_output("perf_wait_count", fetch_wait_count, 32'd8);
`else
        check_output("perf_fetch_count", fetch_count, 32'd0);
        check_output("perf_wait_count", fetch_wait_count, 32'd0);
`endif

        step(32'h200, 0, 0, 32'h0, 0, 0);
        check_output("final_consumed", {31'h0, valid_dec}, 32'h0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 SHALL have parameter NOP_INSTRUCTION, default 32'h00000013, value driven on INSTRUCTION_DECODING when the IF/ID register is invalid.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port PC  input  32  fetch address from the program-counter stage.
REQ-005 SHALL have port FETCH_STALL  output  1  high means the program-counter stage holds PC this cycle.
REQ-006 SHALL have port IMEM_REQ  output  1  instruction-memory request.
REQ-007 SHALL have port IMEM_ADDR  output  32  request address.
REQ-008 SHALL have port IMEM_GNT  input  1  request accepted this cycle.
REQ-009 SHALL have port IMEM_RVALID  input  1  response data valid.
REQ-010 SHALL have port IMEM_RDATA  input  32  response instruction word.
REQ-011 SHALL have port STALL_DECODING_STAGE  input  1  decode cannot accept a new instruction.
REQ-012 SHALL have port CLEAR_DECODING_STAGE  input  1  flush from the program-counter stage on mispredict.
REQ-013 SHALL have port PC_DECODING  output  32  PC of the instruction held in IF/ID.
REQ-014 SHALL have port INSTRUCTION_DECODING  output  32  instruction held in IF/ID.
REQ-015 SHALL have port VALID_DECODING  output  1  IF/ID content is valid.
REQ-016 SHALL have ports FETCH_COUNT and FETCH_WAIT_COUNT  output  32 each  performance counters (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE (nothing outstanding), WAIT (one request granted, awaiting response), HOLD (response parked in one-entry skid buffer).
REQ-018 SHALL support at most one outstanding request.
REQ-019 SHALL assert IMEM_REQ only in IDLE with CLEAR_DECODING_STAGE low, and SHALL drive IMEM_ADDR = PC combinationally.
REQ-020 SHALL, on IMEM_REQ & IMEM_GNT, latch PC into pending_pc and move IDLE -> WAIT.
REQ-021 SHALL drive FETCH_STALL = !(IMEM_REQ & IMEM_GNT).
REQ-022 SHALL, in WAIT on IMEM_RVALID with kill flag clear: load {pending_pc, IMEM_RDATA} into IF/ID with VALID_DECODING=1 and go IDLE if IF/ID is free (VALID_DECODING=0 or STALL_DECODING_STAGE=0), else write the skid buffer and go HOLD.
REQ-023 SHALL, in HOLD, move the buffer into IF/ID and go IDLE on the first cycle STALL_DECODING_STAGE is low.
REQ-024 SHALL clear VALID_DECODING when IF/ID is consumed (STALL_DECODING_STAGE low) and no new entry loads that cycle.
REQ-025 SHALL hold IF/ID unchanged while STALL_DECODING_STAGE is high and VALID_DECODING is high.
REQ-026 SHALL, on CLEAR_DECODING_STAGE: clear VALID_DECODING next edge; in HOLD, discard the buffer and go IDLE; in WAIT, set kill flag.
REQ-027 SHALL, in WAIT with kill flag set, discard the response on IMEM_RVALID, clear kill flag and go IDLE; a same-cycle RVALID and CLEAR also discards.
REQ-028 SHALL give CLEAR_DECODING_STAGE priority over STALL_DECODING_STAGE.
REQ-029 SHALL drive INSTRUCTION_DECODING = NOP_INSTRUCTION whenever VALID_DECODING is low.
REQ-030 SHALL achieve minimum latency of 2 edges from granted request to VALID_DECODING high (GNT in cycle N, RVALID in cycle N+1, valid after edge N+1).

Reset
REQ-031 SHALL, while RST_N is low, force state IDLE, kill flag 0, VALID_DECODING 0, PC_DECODING 0, buffer invalid, both counters 0, without waiting for CLK.
REQ-032 SHALL drop any in-flight response after reset deassertion; IMEM_RVALID in IDLE is ignored.

Configuration
REQ-033 SHALL, with macro FETCH_PERF_COUNTERS_EN defined, increment FETCH_COUNT on each IF/ID load and FETCH_WAIT_COUNT on each cycle in WAIT, both wrapping at 2^32.
REQ-034 SHALL, without FETCH_PERF_COUNTERS_EN, keep both ports present and tied to 32'h0 with no counter flops.

Verification
REQ-035 SHALL cover back-to-back fetch: PC=0x0, GNT immediate, RVALID next cycle, rdata 0x00500093 -> PC_DECODING=0x0, INSTRUCTION_DECODING=0x00500093, VALID_DECODING=1 two edges after request.
REQ-036 SHALL cover decode stall: IF/ID valid, STALL_DECODING_STAGE=1, response 0x00208133 arrives -> state HOLD, IF/ID unchanged; stall drops -> IF/ID holds 0x00208133 next edge.
REQ-037 SHALL cover flush in WAIT: request PC=0x10 granted, CLEAR_DECODING_STAGE pulsed, response arrives -> response dropped, VALID_DECODING=0, INSTRUCTION_DECODING=0x00000013.
REQ-038 SHALL cover memory wait: GNT held low 3 cycles -> FETCH_STALL=1 for those 3 cycles, IMEM_ADDR stable at PC.
REQ-039 SHALL cover asynchronous reset mid-WAIT: RST_N low between edges -> outputs reset immediately; later stale RVALID ignored.
REQ-040 SHALL cover counters with FETCH_PERF_COUNTERS_EN: 4 fetches, each with 2 WAIT cycles -> FETCH_COUNT=4, FETCH_WAIT_COUNT=8.
